// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side controller for the ALU result multiplexer.
// Accepts one operation at a time, drives registered select/operands to the
// ALU, waits LAT cycles, then captures and holds the result on a response port.
// Illegal opcodes and zero divisors are rejected without touching the ALU.
// Optional result flags are enabled with the ALU_SEQ_FLAGS_EN macro.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a command
// ST_EXEC   | ALU inputs applied, counting down the ALU latency
// ST_RESP   | response held on rsp_* until the consumer accepts it

module alu_op_sequencer #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_select,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] alu_outaux,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [N-1:0] rsp_hi,
    output logic         rsp_err,
    output logic         rsp_zero,
    output logic         rsp_neg,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_MOD    = 4'b0100;
    localparam logic [3:0] OP_MULT   = 4'b0101;
    localparam logic [3:0] OP_DIV    = 4'b0110;
    localparam logic [3:0] OP_LAST   = 4'b1001;
    localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   alu_sel_q, alu_sel_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic [N-1:0] rsp_hi_q, rsp_hi_d;
    logic         rsp_err_q, rsp_err_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_neg_q, rsp_neg_d;
    logic         busy_q, busy_d;

    logic         cmd_fire;
    logic         cmd_illegal;
    logic [N-1:0] res_hi;

    // Reset blocks acceptance in the same cycle so rst always wins a handshake.
    assign cmd_ready   = (state_q == ST_IDLE) && !rst;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cmd_illegal = (cmd_op > OP_LAST) ||
                         (((cmd_op == OP_MOD) || (cmd_op == OP_DIV)) && (cmd_b == '0));
    // alu_select still holds the executing op, so it identifies a mult result.
    assign res_hi      = (alu_sel_q == OP_MULT) ? alu_outaux : '0;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_sel_d  = alu_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_data_d = rsp_data_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_err_d  = rsp_err_q;
        rsp_zero_d = rsp_zero_q;
        rsp_neg_d  = rsp_neg_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_illegal) begin
                        rsp_data_d = '0;
                        rsp_hi_d   = '0;
                        rsp_err_d  = 1'b1;
                        rsp_zero_d = 1'b0;
                        rsp_neg_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        alu_sel_d = cmd_op;
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        cnt_d     = CNT_INIT;
                        state_d   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d = alu_out;
                    rsp_hi_d   = res_hi;
                    rsp_err_d  = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                    rsp_zero_d = (alu_out == '0) && (res_hi == '0);
                    rsp_neg_d  = (alu_sel_q == OP_MULT) ? res_hi[N-1] : alu_out[N-1];
`else
                    rsp_zero_d = 1'b0;
                    rsp_neg_d  = 1'b0;
`endif
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            alu_sel_q   <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hi_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_err_q   <= rsp_err_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_select = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_neg    = rsp_neg_q;
    assign busy       = busy_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side controller for the ALU result multiplexer. It accepts one operation at a time over a valid/ready handshake, registers the operands and the 4-bit operation select toward the ALU, and waits a fixed number of cycles. It then captures the multiplexer's `out`/`outaux` result and holds it on a valid/ready response port. It sits between the datapath control and the ALU/multiplexer pair, and rejects illegal opcodes and zero divisors before they reach the ALU.

## Interface
- `N`, 4: operand/result width; must match the multiplexer's `N`.
- `LAT`, 1: cycles the ALU needs after `alu_select`/`alu_a`/`alu_b` change before the result is sampled; legal range 1..15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  4  opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 mod, 0101 mult, 0110 div, 0111 xor, 1000 shl, 1001 shr.
- `cmd_a`, `cmd_b`  in  N each  operands.
- `alu_a`, `alu_b`  out  N each  registered operands to the ALU.
- `alu_select`  out  4  registered select to the multiplexer.
- `alu_out`  in  N  multiplexer `out`.
- `alu_outaux`  in  N  multiplexer `outaux` (mult high half).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  N  result low half.
- `rsp_hi`  out  N  result high half; nonzero only for mult.
- `rsp_err`  out  1  command rejected.
- `rsp_zero`, `rsp_neg`  out  1 each  result flags (see Configuration).
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. `cmd_ready` is 1 only in IDLE, and commands never overlap.
- **IDLE:** on `cmd_valid && cmd_ready`, latch the opcode and operands.
  - **Illegal command:** opcode 1010..1111, or opcode 0100/0110 with `cmd_b == 0`. Go to RESP with `rsp_err=1`, `rsp_data=0`, `rsp_hi=0`. `alu_*` outputs are not updated.
  - **Legal command:** load `alu_select`/`alu_a`/`alu_b` and the wait counter (`LAT-1`), then go to EXEC.
- **EXEC:** decrement the counter each cycle. When the counter reaches 0, capture `rsp_data <= alu_out`, set `rsp_hi <= (op==0101) ? alu_outaux : 0` and `rsp_err <= 0`, then go to RESP.
- **RESP:** `rsp_valid=1`. `rsp_*` outputs are held stable until `rsp_valid && rsp_ready`, then the FSM returns to IDLE. `cmd_valid` is ignored in RESP.
- `alu_select`/`alu_a`/`alu_b` keep the last legal command's values after completion; there is no return to 0.
- Width rules: no internal arithmetic beyond the counter. Shift amount and operand interpretation are owned by the ALU.

## Timing
- **Reset values:** `cmd_ready=0` during the `rst` cycle and 1 in the cycle after. `rsp_valid=0`, `rsp_data=0`, `rsp_hi=0`, `rsp_err=0`, `rsp_zero=0`, `rsp_neg=0`, `alu_select=0000`, `alu_a=0`, `alu_b=0`, `busy=0`, state IDLE.
- **Legal latency:** command accepted at edge k gives `alu_*` valid from cycle k+1 and `rsp_valid` high from cycle k+1+LAT.
- **Error latency:** `rsp_valid` high from cycle k+1.
- **Return to IDLE:** the response handshake at edge m makes `cmd_ready=1` in cycle m+1. Peak throughput is one command per LAT+2 cycles.
- **Reset mid-operation:** `rst` in any state returns to IDLE on that edge. The pending command and any unaccepted response are dropped, and all outputs take their reset values.
- **Simultaneous `rst` and handshake:** `rst` wins; no command is accepted.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined: flags are captured together with the result.
  - `rsp_zero = (rsp_data==0 && rsp_hi==0)`.
  - `rsp_neg` = MSB of `rsp_hi` for mult, otherwise MSB of `rsp_data`.
  - Both flags are forced to 0 on error.
- Not defined: `rsp_zero` and `rsp_neg` are tied to 0; ports remain so instantiations are unchanged.

## Test plan
(N=4, LAT=1)
- add, a=5, b=3 -> `rsp_data=8`, `rsp_hi=0`, `rsp_err=0`; `rsp_valid` 2 cycles after accept; with the macro, `rsp_zero=0`, `rsp_neg=1`.
- mult, a=7, b=6 -> `alu_select=0101`, `rsp_data=0xA`, `rsp_hi=0x2`.
- div, a=9, b=0 -> `rsp_err=1`, `rsp_data=0`, `rsp_valid` 1 cycle after accept, `alu_select` unchanged; opcode 1100 gives the same response.
- Response backpressure: `rsp_ready=0` for 5 cycles -> `rsp_valid`/`rsp_data` stable and `cmd_ready=0` throughout; `cmd_ready=1` the cycle after `rsp_ready` rises.
- `rst` pulsed during EXEC (LAT=3) -> next cycle `rsp_valid=0`, `cmd_ready=1`, `alu_select=0000`; the dropped command never produces a response.
- Back-to-back commands (sub 2-3, then xor 0xF^0x5) with `cmd_valid` held high -> responses `0xF` then `0xA`, each spaced LAT+2 cycles.
